// File: rtl/ow_cmd_sequencer.sv
// ow_cmd_sequencer
// ----------------
// Transaction-level sequencer for a 1-Wire slave, placed directly above the
// byte engine (which owns reset/presence detection and bit slots).
// It decodes the ROM commands Read ROM (0x33), Match ROM (0x55) and
// Skip ROM (0xCC), then the function commands Write Scratchpad (0x4E) and
// Read Scratchpad (0xBE). It steers the engine's direction and transmit byte
// and exposes a small scratchpad register file.
//
// Handshake with the engine: byte_valid is a one-cycle pulse per completed
// byte slot (pulses at least 2 clk apart); the response (dir, tx_byte,
// tx_load, state change) is registered and appears exactly 1 clk later.
// tx_load is a one-cycle strobe and is only ever raised together with dir=1.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   bus_reset_seen    pulse: 1-Wire reset/presence completed (wins over byte_valid)
//   byte_valid        pulse: byte slot completed in the current direction
//   rx_byte[7:0]      received byte, meaningful with byte_valid while dir=0
//   dir               0 = slave receiving, 1 = slave transmitting
//   tx_byte[7:0]      byte the engine transmits next
//   tx_load           strobe: engine captures tx_byte
//   selected          ROM addressing succeeded, cleared by the next bus reset
//   scratch           scratchpad, byte i at [8i+7:8i]
//   scratch_wr        pulse per scratchpad byte written from the bus
//   cmd_error         pulse on unknown command or Match ROM mismatch
//   state_dbg[2:0]    current state, encoded IDLE=0, ROM_CMD=1, READ_ROM=2,
//                     MATCH_ROM=3, FUNC_CMD=4, WR_SCRATCH=5, RD_SCRATCH=6, DONE=7

module ow_cmd_sequencer #(
    parameter logic [63:0] ROM_ID        = 64'h0000_0000_0000_0001,
    parameter int          SCRATCH_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       bus_reset_seen,
    input  logic                       byte_valid,
    input  logic [7:0]                 rx_byte,
    output logic                       dir,
    output logic [7:0]                 tx_byte,
    output logic                       tx_load,
    output logic                       selected,
    output logic [8*SCRATCH_BYTES-1:0] scratch,
    output logic                       scratch_wr,
    output logic                       cmd_error,
    output logic [2:0]                 state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ROM_CMD    = 3'd1,
        ST_READ_ROM   = 3'd2,
        ST_MATCH_ROM  = 3'd3,
        ST_FUNC_CMD   = 3'd4,
        ST_WR_SCRATCH = 3'd5,
        ST_RD_SCRATCH = 3'd6,
        ST_DONE       = 3'd7
    } state_t;

    localparam logic [3:0] ROM_LAST = 4'd7;
    localparam logic [3:0] SCR_LAST = 4'(SCRATCH_BYTES - 1);
    localparam logic [3:0] SCR_CNT  = 4'(SCRATCH_BYTES);

    state_t                     state_q;
    logic                       dir_q;
    logic [7:0]                 tx_byte_q;
    logic                       tx_load_q;
    logic                       selected_q;
    logic [8*SCRATCH_BYTES-1:0] scratch_q;
    logic                       scratch_wr_q;
    logic                       cmd_error_q;
    logic [3:0]                 idx_q;
    logic [8*SCRATCH_BYTES-1:0] snap_q;
    logic [7:0]                 crc_d;

    function automatic logic [7:0] rom_byte(input logic [3:0] i);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (i == 4'(k)) b = ROM_ID[8*k +: 8];
        end
        return b;
    endfunction

    function automatic logic [7:0] pick_byte(input logic [8*SCRATCH_BYTES-1:0] v,
                                             input logic [3:0]                 i);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < SCRATCH_BYTES; k++) begin
            if (i == 4'(k)) b = v[8*k +: 8];
        end
        return b;
    endfunction

    // Dallas CRC-8, bits fed LSB-first starting with byte 0.
    function automatic logic [7:0] dallas_crc(input logic [8*SCRATCH_BYTES-1:0] v);
        logic [7:0] c;
        c = 8'h00;
        for (int k = 0; k < 8*SCRATCH_BYTES; k++) begin
            if (c[0] ^ v[k]) c = (c >> 1) ^ 8'h8C;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // CRC follows the entry snapshot, so it is already settled when the
    // final byte is loaded. A zero snapshot after reset gives crc 0.
    assign crc_d = dallas_crc(snap_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dir_q        <= 1'b0;
            tx_byte_q    <= 8'h00;
            tx_load_q    <= 1'b0;
            selected_q   <= 1'b0;
            scratch_q    <= '0;
            scratch_wr_q <= 1'b0;
            cmd_error_q  <= 1'b0;
            idx_q        <= 4'd0;
            snap_q       <= '0;
        end else begin
            tx_load_q    <= 1'b0;
            scratch_wr_q <= 1'b0;
            cmd_error_q  <= 1'b0;

            if (bus_reset_seen) begin
                // A coincident byte_valid is dropped on purpose.
                state_q    <= ST_ROM_CMD;
                dir_q      <= 1'b0;
                idx_q      <= 4'd0;
                selected_q <= 1'b0;
            end else if (byte_valid) begin
                case (state_q)
                    ST_ROM_CMD: begin
                        idx_q <= 4'd0;
                        case (rx_byte)
                            8'h33: begin
                                state_q   <= ST_READ_ROM;
                                dir_q     <= 1'b1;
                                tx_byte_q <= rom_byte(4'd0);
                                tx_load_q <= 1'b1;
                            end
                            8'h55: state_q <= ST_MATCH_ROM;
                            8'hCC: begin
                                state_q    <= ST_FUNC_CMD;
                                selected_q <= 1'b1;
                            end
                            default: begin
                                state_q     <= ST_DONE;
                                cmd_error_q <= 1'b1;
                            end
                        endcase
                    end

                    ST_READ_ROM: begin
                        if (idx_q == ROM_LAST) begin
                            state_q <= ST_DONE;
                            dir_q   <= 1'b0;
                            idx_q   <= 4'd0;
                        end else begin
                            idx_q     <= idx_q + 4'd1;
                            tx_byte_q <= rom_byte(idx_q + 4'd1);
                            tx_load_q <= 1'b1;
                        end
                    end

                    ST_MATCH_ROM: begin
                        if (rx_byte != rom_byte(idx_q)) begin
                            state_q     <= ST_DONE;
                            cmd_error_q <= 1'b1;
                            idx_q       <= 4'd0;
                        end else if (idx_q == ROM_LAST) begin
                            state_q    <= ST_FUNC_CMD;
                            selected_q <= 1'b1;
                            idx_q      <= 4'd0;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end

                    ST_FUNC_CMD: begin
                        idx_q <= 4'd0;
                        case (rx_byte)
                            8'h4E: state_q <= ST_WR_SCRATCH;
                            8'hBE: begin
                                state_q   <= ST_RD_SCRATCH;
                                snap_q    <= scratch_q;
                                dir_q     <= 1'b1;
                                tx_byte_q <= pick_byte(scratch_q, 4'd0);
                                tx_load_q <= 1'b1;
                            end
                            default: begin
                                state_q     <= ST_DONE;
                                cmd_error_q <= 1'b1;
                            end
                        endcase
                    end

                    ST_WR_SCRATCH: begin
                        for (int k = 0; k < SCRATCH_BYTES; k++) begin
                            if (idx_q == 4'(k)) scratch_q[8*k +: 8] <= rx_byte;
                        end
                        scratch_wr_q <= 1'b1;
                        if (idx_q == SCR_LAST) begin
                            state_q <= ST_DONE;
                            idx_q   <= 4'd0;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                        end
                    end

                    ST_RD_SCRATCH: begin
                        // idx counts completed bytes; byte SCRATCH_BYTES is the CRC.
                        if (idx_q == SCR_CNT) begin
                            state_q <= ST_DONE;
                            dir_q   <= 1'b0;
                            idx_q   <= 4'd0;
                        end else begin
                            idx_q     <= idx_q + 4'd1;
                            tx_load_q <= 1'b1;
                            if (idx_q == SCR_LAST) tx_byte_q <= crc_d;
                            else                   tx_byte_q <= pick_byte(snap_q, idx_q + 4'd1);
                        end
                    end

                    // IDLE (never addressed) and DONE ignore bytes.
                    default: ;
                endcase
            end
        end
    end

    assign dir        = dir_q;
    assign tx_byte    = tx_byte_q;
    assign tx_load    = tx_load_q;
    assign selected   = selected_q;
    assign scratch    = scratch_q;
    assign scratch_wr = scratch_wr_q;
    assign cmd_error  = cmd_error_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_ow_cmd_sequencer.sv
// tb_ow_cmd_sequencer
// -------------------
// Bench for ow_cmd_sequencer. Drives whole 1-Wire transactions (bus reset,
// ROM command, function command, data bytes) and keeps a transaction-level
// model: scratchpad byte array, expected selected flag, expected pulse counts
// and a queue of bytes the slave is expected to transmit.

module tb_ow_cmd_sequencer;

    localparam logic [63:0] TB_ROM = 64'hA2_00000000_1234_28;
    localparam int          NB     = 4;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_ROM_CMD    = 3'd1;
    localparam logic [2:0] S_READ_ROM   = 3'd2;
    localparam logic [2:0] S_FUNC_CMD   = 3'd4;
    localparam logic [2:0] S_WR_SCRATCH = 3'd5;
    localparam logic [2:0] S_RD_SCRATCH = 3'd6;
    localparam logic [2:0] S_DONE       = 3'd7;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            bus_reset_seen = 1'b0;
    logic            byte_valid = 1'b0;
    logic [7:0]      rx_byte = 8'h00;
    logic            dir;
    logic [7:0]      tx_byte;
    logic            tx_load;
    logic            selected;
    logic [8*NB-1:0] scratch;
    logic            scratch_wr;
    logic            cmd_error;
    logic [2:0]      state_dbg;

    always #5 clk = ~clk;

    ow_cmd_sequencer #(
        .ROM_ID        (TB_ROM),
        .SCRATCH_BYTES (NB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus_reset_seen (bus_reset_seen),
        .byte_valid     (byte_valid),
        .rx_byte        (rx_byte),
        .dir            (dir),
        .tx_byte        (tx_byte),
        .tx_load        (tx_load),
        .selected       (selected),
        .scratch        (scratch),
        .scratch_wr     (scratch_wr),
        .cmd_error      (cmd_error),
        .state_dbg      (state_dbg)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [7:0] rom_b[8];
    logic [7:0] m_scr[NB];
    logic [7:0] wdata[8];
    int         exp_wr  = 0;
    int         exp_err = 0;

    function automatic logic [8*NB-1:0] model_flat();
        logic [8*NB-1:0] f;
        for (int i = 0; i < NB; i++) f[8*i +: 8] = m_scr[i];
        return f;
    endfunction

    // Dallas CRC-8: message bits shifted in LSB-first, remainder register
    // in reflected form with polynomial constant 0x8C.
    function automatic logic [7:0] model_crc();
        logic [7:0] rem;
        logic       fb;
        rem = 8'h00;
        for (int i = 0; i < NB; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb  = rem[0] ^ m_scr[i][b];
                rem = {1'b0, rem[7:1]};
                if (fb) rem = rem ^ 8'h8C;
            end
        end
        return rem;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [7:0] exp_q[$];
    int         last_bv_cyc = 0;
    int         wr_cnt = 0;
    int         err_cnt = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (tx_load) begin
                check("tx_dir", 64'(dir), 64'(1));
                check("tx_latency", 64'(cyc), 64'(last_bv_cyc + 1));
                if (exp_q.size() == 0) check("tx_unexpected", 64'(tx_load), 64'(0));
                else                   check("tx_byte", 64'(tx_byte), 64'(exp_q.pop_front()));
            end
            if (scratch_wr) wr_cnt++;
            if (cmd_error)  err_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        byte_valid  = 1'b1;
        rx_byte     = b;
        last_bv_cyc = cyc;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        rx_byte    = 8'($urandom_range(0, 255));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_reset();
        @(posedge clk); #1;
        bus_reset_seen = 1'b1;
        @(posedge clk); #1;
        bus_reset_seen = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_reset_with_byte();
        @(posedge clk); #1;
        bus_reset_seen = 1'b1;
        byte_valid     = 1'b1;
        last_bv_cyc    = cyc;
        @(posedge clk); #1;
        bus_reset_seen = 1'b0;
        byte_valid     = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_address(input bit use_match);
        bus_reset();
        if (use_match) begin
            send_byte(8'h55);
            for (int i = 0; i < 8; i++) send_byte(rom_b[i]);
        end else begin
            send_byte(8'hCC);
        end
        check("selected_after_addr", 64'(selected), 64'(1));
        check("state_after_addr", 64'(state_dbg), 64'(S_FUNC_CMD));
    endtask

    task automatic do_write(input bit use_match, input int nbytes);
        do_address(use_match);
        send_byte(8'h4E);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(wdata[i]);
            if (i < NB) begin
                m_scr[i] = wdata[i];
                exp_wr++;
            end
        end
        check("scratch", 64'(scratch), 64'(model_flat()));
        check("wr_count", 64'(wr_cnt), 64'(exp_wr));
        check("state_after_write", 64'(state_dbg), 64'((nbytes >= NB) ? S_DONE : S_WR_SCRATCH));
    endtask

    task automatic do_read(input bit use_match);
        do_address(use_match);
        for (int i = 0; i < NB; i++) exp_q.push_back(m_scr[i]);
        exp_q.push_back(model_crc());
        send_byte(8'hBE);
        check("rd_dir_on", 64'(dir), 64'(1));
        check("rd_state", 64'(state_dbg), 64'(S_RD_SCRATCH));
        repeat (NB + 1) send_byte(8'($urandom_range(0, 255)));
        check("rd_remaining", 64'(exp_q.size()), 64'(0));
        check("rd_dir_off", 64'(dir), 64'(0));
        check("rd_state_end", 64'(state_dbg), 64'(S_DONE));
    endtask

    function automatic logic [7:0] bad_cmd(input bit rom_level);
        logic [7:0] c;
        do begin
            c = 8'($urandom_range(0, 255));
        end while (rom_level ? (c == 8'h33 || c == 8'h55 || c == 8'hCC)
                             : (c == 8'h4E || c == 8'hBE));
        return c;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 8; i++) rom_b[i] = 8'(TB_ROM >> (8*i));
        for (int i = 0; i < NB; i++) m_scr[i] = 8'h00;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_dir", 64'(dir), 64'(0));
        check("rst_tx_byte", 64'(tx_byte), 64'(0));
        check("rst_tx_load", 64'(tx_load), 64'(0));
        check("rst_selected", 64'(selected), 64'(0));
        check("rst_scratch", 64'(scratch), 64'(0));
        check("rst_cmd_error", 64'(cmd_error), 64'(0));
        check("rst_state", 64'(state_dbg), 64'(S_IDLE));
        reset = 1'b0;
        @(negedge clk);

        // Bytes before any bus reset are ignored.
        send_byte(8'hCC);
        check("idle_ignores_byte", 64'(state_dbg), 64'(S_IDLE));
        check("idle_selected", 64'(selected), 64'(0));

        // Skip ROM, write 11 22 33 44; an extra byte is ignored.
        wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
        wdata[4] = 8'h99;
        do_write(1'b0, 5);
        check("scratch_plan", 64'(scratch), 64'(32'h44332211));

        // Read ROM.
        bus_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back(rom_b[i]);
        send_byte(8'h33);
        check("rom_dir_on", 64'(dir), 64'(1));
        check("rom_state", 64'(state_dbg), 64'(S_READ_ROM));
        repeat (8) send_byte(8'($urandom_range(0, 255)));
        check("rom_remaining", 64'(exp_q.size()), 64'(0));
        check("rom_dir_off", 64'(dir), 64'(0));
        check("rom_state_end", 64'(state_dbg), 64'(S_DONE));

        // Match ROM with byte 3 corrupted; later BE must not transmit.
        bus_reset();
        send_byte(8'h55);
        for (int i = 0; i < 3; i++) send_byte(rom_b[i]);
        check("match_no_err_yet", 64'(err_cnt), 64'(exp_err));
        send_byte(rom_b[3] ^ 8'h5A);
        exp_err++;
        check("match_err", 64'(err_cnt), 64'(exp_err));
        check("match_sel", 64'(selected), 64'(0));
        check("match_state", 64'(state_dbg), 64'(S_DONE));
        for (int i = 4; i < 8; i++) send_byte(rom_b[i]);
        send_byte(8'hBE);
        check("match_err_after", 64'(err_cnt), 64'(exp_err));
        check("match_dir", 64'(dir), 64'(0));

        // Read back 11 22 33 44 plus CRC through Skip ROM, then Match ROM.
        do_read(1'b0);
        do_read(1'b1);

        // Bus reset coincident with byte_valid after ROM byte 2.
        bus_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back(rom_b[i]);
        send_byte(8'h33);
        send_byte(8'h00);
        send_byte(8'h00);
        bus_reset_with_byte();
        check("coinc_dir", 64'(dir), 64'(0));
        check("coinc_state", 64'(state_dbg), 64'(S_ROM_CMD));
        check("coinc_remaining", 64'(exp_q.size()), 64'(0));
        check("coinc_sel", 64'(selected), 64'(0));
        send_byte(8'hCC);
        check("coinc_cc_sel", 64'(selected), 64'(1));

        // Randomized transactions.
        for (int t = 0; t < 16; t++) begin
            case ($urandom_range(0, 3))
                0: begin
                    for (int i = 0; i < 8; i++) wdata[i] = 8'($urandom_range(0, 255));
                    do_write(1'($urandom_range(0, 1)), $urandom_range(1, 6));
                end
                1: do_read(1'($urandom_range(0, 1)));
                2: begin
                    bus_reset();
                    send_byte(bad_cmd(1'b1));
                    exp_err++;
                    check("bad_rom_err", 64'(err_cnt), 64'(exp_err));
                    check("bad_rom_state", 64'(state_dbg), 64'(S_DONE));
                    check("bad_rom_sel", 64'(selected), 64'(0));
                end
                default: begin
                    do_address(1'($urandom_range(0, 1)));
                    send_byte(bad_cmd(1'b0));
                    exp_err++;
                    check("bad_func_err", 64'(err_cnt), 64'(exp_err));
                    check("bad_func_state", 64'(state_dbg), 64'(S_DONE));
                end
            endcase
        end
        do_read(1'b0);

        // Asynchronous reset in the middle of a scratchpad write.
        do_address(1'b0);
        send_byte(8'h4E);
        send_byte(8'hA5);
        send_byte(8'h5A);
        check("pre_arst_state", 64'(state_dbg), 64'(S_WR_SCRATCH));
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        check("arst_scratch", 64'(scratch), 64'(0));
        check("arst_selected", 64'(selected), 64'(0));
        check("arst_dir", 64'(dir), 64'(0));
        check("arst_tx_byte", 64'(tx_byte), 64'(0));
        check("arst_tx_load", 64'(tx_load), 64'(0));
        check("arst_wr", 64'(scratch_wr), 64'(0));
        check("arst_err", 64'(cmd_error), 64'(0));
        check("arst_state", 64'(state_dbg), 64'(S_IDLE));
        for (int i = 0; i < NB; i++) m_scr[i] = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // After reset the scratchpad reads back as zeros with CRC 0.
        do_read(1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ow_cmd_sequencer.md
# ow_cmd_sequencer

Transaction-level sequencer for a 1-Wire slave. It sits directly above the 1-Wire slave byte engine, which performs reset/presence handling and bit slots. It decodes ROM commands (Read ROM 0x33, Match ROM 0x55, Skip ROM 0xCC) and function commands (Write Scratchpad 0x4E, Read Scratchpad 0xBE). It steers the engine's direction and transmit byte, and exposes a small scratchpad register file to the rest of the design.

## Interface
- ROM_ID, 64'h0000_0000_0000_0001, device ROM; byte 0 (bits 7:0) is the first byte on the wire; byte 7 carries the ROM CRC and is sent verbatim.
- SCRATCH_BYTES, 4, scratchpad depth, legal range 1..8.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high.
- bus_reset_seen  input  1  one-cycle pulse, clk-synchronous; a 1-Wire reset/presence sequence completed.
- byte_valid  input  1  one-cycle pulse; a full byte slot completed in the current direction.
- rx_byte  input  8  received byte; valid when byte_valid is high and dir is 0.
- dir  output  1  0 = slave receiving, 1 = slave transmitting.
- tx_byte  output  8  next byte for the engine to transmit.
- tx_load  output  1  one-cycle strobe; the engine captures tx_byte on it.
- selected  output  1  high once ROM addressing succeeds (Skip ROM or Match ROM hit), until the next bus reset.
- scratch  output  8*SCRATCH_BYTES  scratchpad contents; byte i is at bits [8i+7:8i].
- scratch_wr  output  1  one-cycle pulse per scratchpad byte written from the bus.
- cmd_error  output  1  one-cycle pulse on unknown command or Match ROM mismatch.

## Operation
- States:
  - IDLE: powered up, not yet addressed.
  - ROM_CMD
  - READ_ROM
  - MATCH_ROM
  - FUNC_CMD
  - WR_SCRATCH
  - RD_SCRATCH
  - DONE: ignore all bytes.
- Reset values: state IDLE, dir 0, tx_byte 8'h00, tx_load 0, selected 0, scratch all zero, scratch_wr 0, cmd_error 0, byte index 0, crc 0.
- bus_reset_seen, from any state, does the following:
  - Go to ROM_CMD with dir=0, index=0, selected=0.
  - Scratch is preserved.
  - It takes priority over a simultaneous byte_valid; that byte is dropped.
- ROM_CMD, on byte_valid:
  - 0x33 → READ_ROM.
  - 0x55 → MATCH_ROM.
  - 0xCC → FUNC_CMD, selected=1.
  - Anything else → DONE with cmd_error pulse.
- READ_ROM:
  - On entry: dir=1, tx_byte=ROM byte 0, tx_load pulse.
  - Each byte_valid: index++ and load the next ROM byte.
  - After byte_valid for byte 7: dir=0, no tx_load, → DONE.
- MATCH_ROM: each byte_valid compares rx_byte to ROM byte[index].
  - Mismatch → DONE with cmd_error pulse; the rest of the bytes are ignored.
  - 8 matches → FUNC_CMD, selected=1.
- FUNC_CMD, on byte_valid:
  - 0x4E → WR_SCRATCH.
  - 0xBE → RD_SCRATCH.
  - Anything else → DONE with cmd_error pulse.
- WR_SCRATCH:
  - Each byte_valid writes scratch[index]=rx_byte, pulses scratch_wr, index++.
  - After SCRATCH_BYTES bytes → DONE; further bytes are ignored.
- RD_SCRATCH:
  - Transmits scratch[0..SCRATCH_BYTES-1], then one CRC byte, loaded on entry and on each byte_valid as in READ_ROM.
  - CRC is Dallas CRC-8 (x^8+x^5+x^4+1, LSB-first, reflected constant 0x8C, init 0x00) over the transmitted scratch bytes.
  - After the CRC byte completes: dir=0 → DONE.
- The index counter is 4 bits wide and is cleared on every state change.
- The scratch snapshot used for RD_SCRATCH is taken at entry, so the transmitted data and CRC stay consistent.

## Timing
- All outputs are registered.
- Response latency is exactly 1 clk after the triggering byte_valid:
  - dir and tx_byte change in the same cycle as tx_load.
  - The state transition happens in that same cycle.
- tx_load is never asserted while dir=0.
- The first tx_load of a transmit state appears 1 clk after the command byte's byte_valid.
- The CRC is computed combinationally from the snapshot and is ready at the load of the final byte; no extra latency.
- byte_valid pulses must be at least 2 clk apart; closer spacing is out of contract.
- Asynchronous reset mid-transaction forces reset values immediately, scratch included.

## Test plan
- Skip ROM then write scratchpad: bus reset, CC, 4E, 11 22 33 44 → scratch=32'h44332211, four scratch_wr pulses, selected=1, state DONE.
- Read ROM with ROM_ID=64'hA2_00000000_1234_28: bus reset, 33 → eight tx_load strobes carrying 28 34 12 00 00 00 00 A2, then dir=0.
- Match ROM mismatch: bus reset, 55, then the ROM bytes with byte 3 corrupted → cmd_error on byte 3, selected stays 0, a following BE produces no tx_load.
- Read scratchpad after the write of 11 22 33 44: bus reset, CC, BE → tx 11 22 33 44, then Dallas CRC-8 of those bytes, then dir=0.
- Bus reset during READ_ROM after byte 2, coincident with byte_valid → dir=0 next cycle, state ROM_CMD, no tx_load; a subsequent CC sets selected.
- Asynchronous reset asserted during WR_SCRATCH → scratch=0 and all outputs at reset values without waiting for a clk edge.
